frame_store_buffer: RTL and testbench

- Store-and-forward byte buffer directly downstream of the clocked byte-register stage in the sensitivity test block.
- Captures bytes qualified by an enable strobe and groups them into fixed-length frames.
- Releases only complete frames to a valid/ready consumer.
- If space runs out mid-frame, the whole frame is discarded so the consumer never sees a partial frame.

---
 rtl/frame_store_buffer.sv | 147 ++++++++++++++
 tb/tb_frame_store_buffer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_store_buffer.sv
// frame_store_buffer: store-and-forward byte buffer that groups enabled
// input bytes into fixed-length frames and releases only complete frames.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   in_en, in_data    byte strobe and byte from upstream (no backpressure)
//   out_valid         committed byte available at head
//   out_data          head byte
//   out_last          head byte closes its frame
//   out_ready         consumer accepts the head byte
//   out_count         committed bytes available
//   overflow          sticky, set on the first dropped byte
//   drop_cnt          saturating dropped-frame counter
//
// Optional feature macro: FRAME_STORE_DROP_CNT_EN enables drop_cnt;
// without it drop_cnt is tied to zero.
`timescale 1ns/1ps

module frame_store_buffer #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int FRAME_LEN = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_en,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_last,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     out_count,
    output logic                       overflow,
    output logic [7:0]                 drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int IW = $clog2(FRAME_LEN);

    typedef enum logic {
        COLLECT = 1'b0,
        DISCARD = 1'b1
    } state_t;

    state_t              state_q;
    logic [PW-1:0]       wr_ptr_q;
    logic [PW-1:0]       rd_ptr_q;
    logic [PW-1:0]       commit_ptr_q;
    logic [PW-1:0]       frame_start_q;
    logic [IW-1:0]       byte_idx_q;
    logic                overflow_q;
    logic [DATA_W:0]     mem_q [DEPTH];

    logic [PW-1:0]       occupancy;
    logic                full;
    logic                is_last;
    logic                pop;
    logic                push;
    logic                drop_frame;
    logic [DATA_W:0]     head;

    assign occupancy  = wr_ptr_q - rd_ptr_q;
    // Fullness uses pre-pop occupancy; a same-cycle pop frees no room.
    assign full       = (occupancy == PW'(DEPTH));
    assign is_last    = (byte_idx_q == IW'(FRAME_LEN - 1));
    assign push       = in_en && (state_q == COLLECT) && !full;
    assign drop_frame = in_en && (state_q == COLLECT) && full;

    assign out_count  = commit_ptr_q - rd_ptr_q;
    assign out_valid  = (out_count != '0);
    assign pop        = out_valid && out_ready;

    // Gate the head so outputs read as zero while nothing is committed.
    assign head       = out_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
    assign out_last   = head[DATA_W];
    assign out_data   = head[DATA_W-1:0];
    assign overflow   = overflow_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {is_last, in_data};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= COLLECT;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            commit_ptr_q  <= '0;
            frame_start_q <= '0;
            byte_idx_q    <= '0;
            overflow_q    <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (in_en) begin
                // Index advances on every strobe to keep frame alignment.
                byte_idx_q <= is_last ? '0 : byte_idx_q + 1'b1;
                unique case (state_q)
                    COLLECT: begin
                        if (push) begin
                            wr_ptr_q <= wr_ptr_q + 1'b1;
                            if (is_last) begin
                                commit_ptr_q  <= wr_ptr_q + 1'b1;
                                frame_start_q <= wr_ptr_q + 1'b1;
                            end
                        end else if (drop_frame) begin
                            // Rewind the uncommitted part of this frame.
                            overflow_q <= 1'b1;
                            wr_ptr_q   <= frame_start_q;
                            if (!is_last) begin
                                state_q <= DISCARD;
                            end
                        end
                    end
                    DISCARD: begin
                        overflow_q <= 1'b1;
                        if (is_last) begin
                            state_q <= COLLECT;
                        end
                    end
                    default: state_q <= COLLECT;
                endcase
            end
        end
    end

`ifdef FRAME_STORE_DROP_CNT_EN
    logic [7:0] drop_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else if (drop_frame && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_frame_store_buffer.sv
// tb_frame_store_buffer: directed scenarios plus random traffic for
// frame_store_buffer, checked against a queue-based frame model.
`timescale 1ns/1ps

module tb_frame_store_buffer;

    localparam int DEPTH = 8;
    localparam int FL    = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_en = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic [3:0] out_count;
    logic       overflow;
    logic [7:0] drop_cnt;

    int vectors = 0;
    int miscompares = 0;

    frame_store_buffer #(
        .DATA_W(8), .DEPTH(DEPTH), .FRAME_LEN(FL)
    ) dut (
        .clk(clk), .reset(reset),
        .in_en(in_en), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_ready(out_ready),
        .out_count(out_count), .overflow(overflow),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: committed frames, the frame being gathered,
    // and whether the rest of the current frame is being thrown away.
    logic [8:0] m_commit[$];
    logic [7:0] m_pend[$];
    int         m_idx;
    bit         m_discard;
    bit         m_ovf;
    int         m_drops;

    wire [22:0] got = {out_valid, out_last, out_data, out_count,
                       overflow, drop_cnt};

    function automatic void model_reset();
        m_commit.delete();
        m_pend.delete();
        m_idx = 0;
        m_discard = 0;
        m_ovf = 0;
        m_drops = 0;
    endfunction

    function automatic void model_step(bit en, logic [7:0] d, bit rdy);
        bit full;
        full = (m_commit.size() + m_pend.size()) == DEPTH;
        if (rdy && m_commit.size() > 0) void'(m_commit.pop_front());
        if (en) begin
            if (m_discard) begin
                m_ovf = 1;
                if (m_idx == FL - 1) m_discard = 0;
            end else if (full) begin
                m_ovf = 1;
                m_pend.delete();
                if (m_drops < 255) m_drops++;
                if (m_idx != FL - 1) m_discard = 1;
            end else begin
                m_pend.push_back(d);
                if (m_idx == FL - 1) begin
                    foreach (m_pend[k])
                        m_commit.push_back({k == FL - 1, m_pend[k]});
                    m_pend.delete();
                end
            end
            m_idx = (m_idx + 1) % FL;
        end
    endfunction

    function automatic logic [22:0] exp_vec();
        logic [8:0] h;
        logic [7:0] dc;
        h = (m_commit.size() > 0) ? m_commit[0] : 9'h000;
`ifdef FRAME_STORE_DROP_CNT_EN
        dc = 8'(m_drops);
`else
        dc = 8'h00;
`endif
        return {m_commit.size() > 0, h[8], h[7:0],
                4'(m_commit.size()), m_ovf, dc};
    endfunction

    task automatic cycle(input bit en, input logic [7:0] d,
                         input bit rdy);
        @(negedge clk);
        in_en = en;
        in_data = d;
        out_ready = rdy;
        @(posedge clk);
        model_step(en, d, rdy);
        #1;
        in_en = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        in_en = 1'b0;
        out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if (got !== 23'h0) begin
            miscompares++;
            $display("FAIL reset: got %h want 0", got);
        end
    endtask

    task automatic test_basic();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1, 8'h11 + 8'(i), 0);
            vectors++;
            if (got !== exp_vec()) begin
                miscompares++;
                $display("FAIL basic_push%0d: got %h want %h",
                         i, got, exp_vec());
            end
        end
        vectors++;
        if (out_count !== 4'd4 || out_data !== 8'h11 || !out_valid) begin
            miscompares++;
            $display("FAIL basic_head: count %0d data %h want 4/11",
                     out_count, out_data);
        end
        for (int i = 0; i < 5; i++) begin
            cycle(0, 8'h00, 1);
            vectors++;
            if (got !== exp_vec()) begin
                miscompares++;
                $display("FAIL basic_pop%0d: got %h want %h",
                         i, got, exp_vec());
            end
        end
    endtask

    // Drain everything and compare against an explicit byte list.
    task automatic drain_expect(input string nm, input logic [7:0] first,
                                input int n);
        logic [8:0] seen[$];
        int guard = 0;
        while (out_valid && guard < 40) begin
            seen.push_back({out_last, out_data});
            cycle(0, 8'h00, 1);
            guard++;
            vectors++;
            if (got !== exp_vec()) begin
                miscompares++;
                $display("FAIL %s_drain: got %h want %h",
                         nm, got, exp_vec());
            end
        end
        vectors++;
        if (seen.size() != n) begin
            miscompares++;
            $display("FAIL %s_len: got %0d want %0d", nm, seen.size(), n);
        end
        foreach (seen[k]) begin
            logic [8:0] w;
            w = {((32'(first) + k) % FL) == 0, first + 8'(k)};
            vectors++;
            if (seen[k] !== w) begin
                miscompares++;
                $display("FAIL %s_byte%0d: got %h want %h",
                         nm, k, seen[k], w);
            end
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 1; i <= 8; i++) cycle(1, 8'(i), 0);
        vectors++;
        if (out_count !== 4'd8) begin
            miscompares++;
            $display("FAIL ovf_count: got %0d want 8", out_count);
        end
        cycle(1, 8'h09, 0);
        vectors++;
        if (got !== exp_vec() || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_drop: got %h want %h", got, exp_vec());
        end
        for (int i = 10; i <= 12; i++) cycle(1, 8'(i), 0);
        // Back in COLLECT: the next frame is dropped again (still full).
        cycle(1, 8'h0D, 0);
        vectors++;
        if (got !== exp_vec()) begin
            miscompares++;
            $display("FAIL ovf_realign: got %h want %h", got, exp_vec());
        end
        for (int i = 14; i <= 16; i++) cycle(1, 8'(i), 0);
        drain_expect("ovf", 8'h01, 8);
    endtask

    task automatic test_rewind();
        apply_reset();
        for (int i = 1; i <= 4; i++) cycle(1, 8'(i), 0);
        cycle(0, 8'h00, 1);
        vectors++;
        if (out_count !== 4'd3) begin
            miscompares++;
            $display("FAIL rew_count3: got %0d want 3", out_count);
        end
        for (int i = 5; i <= 9; i++) cycle(1, 8'(i), 0);
        vectors++;
        if (out_count !== 4'd7 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL rew_count7: got %0d/%b want 7/0",
                     out_count, overflow);
        end
        for (int i = 10; i <= 12; i++) begin
            cycle(1, 8'(i), 0);
            vectors++;
            if (got !== exp_vec()) begin
                miscompares++;
                $display("FAIL rew_drop%0d: got %h want %h",
                         i, got, exp_vec());
            end
        end
        // Space freed by the rewind must accept a fresh frame.
        drain_expect("rew", 8'h02, 7);
        for (int i = 0; i < 4; i++) cycle(1, 8'h41 + 8'(i), 0);
        drain_expect("rew_after", 8'h41, 4);
    endtask

    task automatic test_full_pop();
        apply_reset();
        for (int i = 1; i <= 8; i++) cycle(1, 8'(i), 0);
        cycle(1, 8'h99, 1);
        vectors++;
        if (got !== exp_vec() || out_count !== 4'd7
            || overflow !== 1'b1 || out_data !== 8'h02) begin
            miscompares++;
            $display("FAIL full_pop: got %h want %h", got, exp_vec());
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        cycle(1, 8'h21, 0);
        cycle(1, 8'h22, 0);
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (got !== 23'h0) begin
            miscompares++;
            $display("FAIL midrst_async: got %h want 0", got);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) cycle(1, 8'h31 + 8'(i), 0);
        vectors++;
        if (out_data !== 8'h31 || out_count !== 4'd4) begin
            miscompares++;
            $display("FAIL midrst_head: data %h count %0d want 31/4",
                     out_data, out_count);
        end
        drain_expect("midrst", 8'h31, 4);
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 3) != 0, 8'($urandom),
                  $urandom_range(0, 2) == 0);
            vectors++;
            if (got !== exp_vec()) begin
                miscompares++;
                $display("FAIL random%0d: got %h want %h",
                         i, got, exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_overflow();
        test_rewind();
        test_full_pop();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
